// File: rtl/nibble_serial_adder_ctrl_if.sv
// Handshake and adder-side signal bundle for nibble_serial_adder_ctrl.
// master = requester plus the external 4-bit adder, slave = the controller.
interface nibble_serial_adder_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_s;
    logic         add_cout;

    modport master (
        output start, op_a, op_b, cin, add_s, add_cout,
        input  busy, done, sum, cout, ovf, add_a, add_b, add_cin
    );

    modport slave (
        input  start, op_a, op_b, cin, add_s, add_cout,
        output busy, done, sum, cout, ovf, add_a, add_b, add_cin
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial adder controller: feeds one external 4-bit adder a nibble per
// cycle, chains the carry in a register and assembles a W-bit sum.
module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    nibble_serial_adder_ctrl_if.slave    bus
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [3:0]         nib_a, nib_b;

    always_comb begin
        nib_a = 4'h0;
        nib_b = 4'h0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (int'(idx_q) == n) begin
                nib_a = a_q[4*n +: 4];
                nib_b = b_q[4*n +: 4];
            end
        end
    end

    // Adder inputs are quiet outside RUN so the adder sees no stray activity.
    assign bus.add_a   = (state_q == RUN) ? nib_a : 4'h0;
    assign bus.add_b   = (state_q == RUN) ? nib_b : 4'h0;
    assign bus.add_cin = (state_q == RUN) & carry_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    a_d     = bus.op_a;
                    b_d     = bus.op_b;
                    carry_d = bus.cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int n = 0; n < NIBBLES; n++) begin
                    if (int'(idx_q) == n) begin
                        sum_d[4*n +: 4] = bus.add_s;
                    end
                end
                carry_d = bus.add_cout;
                if (int'(idx_q) == NIBBLES - 1) begin
                    cout_d  = bus.add_cout;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (bus.add_s[3] != a_q[W-1]);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl: directed vector table, multi-cycle corner
// sequences and a back-to-back random run against an arithmetic reference.
module tb_nibble_serial_adder_ctrl;
    localparam int NIB = 4;
    localparam int W   = 16;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    nibble_serial_adder_ctrl_if #(.NIBBLES(NIB)) bus ();

    nibble_serial_adder_ctrl #(.NIBBLES(NIB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural stand-in for the team's 4-bit adder.
    assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'b0000, bus.add_cin};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Carry entering nibble i, from the plain integer sum of the lower bits.
    function automatic logic carry_into(input logic [15:0] a, input logic [15:0] b,
                                        input logic c, input int i);
        int unsigned m;
        if (i == 0) return c;
        m = (32'd1 << (4 * i)) - 32'd1;
        return 1'((({16'h0, a} & m) + ({16'h0, b} & m) + {31'h0, c}) >> (4 * i));
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                          input logic [15:0] es, input logic eco, input logic eov,
                          input string tag);
        logic [3:0] ra[NIB];
        logic [3:0] rb[NIB];
        logic       rc[NIB];
        int         nb;
        int         done_at;
        @(negedge clk);
        bus.op_a = a; bus.op_b = b; bus.cin = c; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        nb = 0;
        done_at = 0;
        for (int t = 1; t <= 12 && done_at == 0; t++) begin
            if (t > 1) @(negedge clk);
            if (bus.busy) begin
                if (nb < NIB) begin
                    ra[nb] = bus.add_a;
                    rb[nb] = bus.add_b;
                    rc[nb] = bus.add_cin;
                end
                nb++;
            end
            if (bus.done) done_at = t;
            bus.op_a = 16'($urandom);
            bus.op_b = 16'($urandom);
            bus.cin  = 1'($urandom);
        end
        check({tag, ".busy_cycles"}, nb, NIB);
        check({tag, ".done_latency"}, done_at, NIB + 1);
        check({tag, ".sum"}, bus.sum, es);
        check({tag, ".cout"}, bus.cout, eco);
        check({tag, ".ovf"}, bus.ovf, eov);
        if (nb == NIB) begin
            for (int i = 0; i < NIB; i++) begin
                check($sformatf("%s.add_a[%0d]", tag, i), ra[i], a[4*i +: 4]);
                check($sformatf("%s.add_b[%0d]", tag, i), rb[i], b[4*i +: 4]);
                check($sformatf("%s.add_cin[%0d]", tag, i), rc[i], carry_into(a, b, c, i));
            end
        end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, ".done_single"}, bus.done, 1'b0);
        check({tag, ".start_in_done_ignored"}, bus.busy, 1'b0);
        check({tag, ".sum_held"}, bus.sum, es);
        check({tag, ".idle_adder_in"}, {bus.add_a, bus.add_b, bus.add_cin}, 9'h0);
        @(negedge clk);
        check({tag, ".still_idle"}, bus.busy, 1'b0);
    endtask

    logic [32:0] hist[1600];

    initial begin
        int          ndone;
        int          prev_t;
        int          src;
        logic [16:0] full;
        logic        e_ov;
        logic [15:0] sum_at;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.cin = 1'b0;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

        #12;
        check("reset.busy", bus.busy, 1'b0);
        check("reset.done", bus.done, 1'b0);
        check("reset.sum", bus.sum, 16'h0);
        check("reset.cout", bus.cout, 1'b0);
        check("reset.ovf", bus.ovf, 1'b0);
        check("reset.adder_in", {bus.add_a, bus.add_b, bus.add_cin}, 9'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            run_op(vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].s, vecs[v].co, vecs[v].ov,
                   $sformatf("vec%0d", v));
        end

        // start re-pulsed with new operands while the first add is in RUN
        @(negedge clk);
        bus.op_a = 16'h0001; bus.op_b = 16'h0001; bus.cin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.op_a = 16'hAAAA; bus.op_b = 16'h5555; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        ndone = 0;
        sum_at = 16'hDEAD;
        for (int t = 0; t < 14; t++) begin
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                sum_at = bus.sum;
            end
        end
        check("busy_ignore.done_count", ndone, 1);
        check("busy_ignore.sum", sum_at, 16'h0002);
        check("busy_ignore.idle_after", bus.busy, 1'b0);

        // asynchronous reset between edges while idx=2
        @(negedge clk);
        bus.op_a = 16'h1111; bus.op_b = 16'h2222; bus.cin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midreset.partial_sum_visible", bus.sum, 16'h0033);
        #2 rst_n = 1'b0;
        #1;
        check("midreset.busy", bus.busy, 1'b0);
        check("midreset.done", bus.done, 1'b0);
        check("midreset.sum", bus.sum, 16'h0);
        check("midreset.cout", bus.cout, 1'b0);
        check("midreset.ovf", bus.ovf, 1'b0);
        check("midreset.adder_in", {bus.add_a, bus.add_b, bus.add_cin}, 9'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (bus.done || bus.busy) ndone++;
        end
        check("midreset.no_activity_after", ndone, 0);
        run_op(16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0, "after_reset");

        // back-to-back: start held high, fresh random operands every cycle
        ndone  = 0;
        prev_t = 0;
        for (int t = 0; t < 1500 && ndone < 200; t++) begin
            @(negedge clk);
            if (bus.done) begin
                src  = t - (NIB + 1);
                full = {1'b0, hist[src][32:17]} + {1'b0, hist[src][16:1]} + {16'h0, hist[src][0]};
                e_ov = (hist[src][32] == hist[src][16]) && (full[15] != hist[src][32]);
                check($sformatf("b2b%0d.sum", ndone), bus.sum, full[15:0]);
                check($sformatf("b2b%0d.cout", ndone), bus.cout, full[16]);
                check($sformatf("b2b%0d.ovf", ndone), bus.ovf, e_ov);
                if (ndone > 0) check($sformatf("b2b%0d.period", ndone), t - prev_t, NIB + 2);
                prev_t = t;
                ndone++;
            end
            bus.op_a  = 16'($urandom);
            bus.op_b  = 16'($urandom);
            bus.cin   = 1'($urandom);
            bus.start = 1'b1;
            hist[t]   = {bus.op_a, bus.op_b, bus.cin};
        end
        check("b2b.result_count", ndone, 200);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        check("b2b.idle_after", bus.busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Iterative (nibble-serial) adder controller that drives the team's 4-bit adder, `adder4b`, over several clock cycles.
- Computes a W = 4*NIBBLES bit sum with one `adder4b` instance.
- Acts as both the upstream feeder of the adder (A, B, Cin) and the downstream consumer of its results (S, Cout).
- Registers the carry between nibbles and assembles the full-width result with a start/busy/done handshake.

Parameters:
- NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES (legal range 2..8).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new addition; sampled only in IDLE.
- op_a  input  W  operand A; captured when start is accepted.
- op_b  input  W  operand B; captured when start is accepted.
- cin  input  1  carry-in; captured when start is accepted.
- busy  output  1  high while an addition is in progress (RUN).
- done  output  1  single-cycle pulse; result is valid.
- sum  output  W  registered result; held until the next accepted start.
- cout  output  1  unsigned carry out of bit W-1.
- ovf  output  1  signed (two's-complement) overflow flag.
- add_a  output  4  to adder A: the current nibble of A.
- add_b  output  4  to adder B: the current nibble of B.
- add_cin  output  1  to adder Cin: the registered inter-nibble carry.
- add_s  input  4  from adder S.
- add_cout  input  1  from adder Cout.

Behaviour:
- Reset (rst_n low, asynchronous, any state): all outputs go to 0 immediately.
  - Affected: state=IDLE, busy, done, sum, cout, ovf, idx, carry register, operand registers.
- The in-flight operation is discarded; no done is produced for it.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a rising edge: capture op_a, op_b into a_reg, b_reg; carry_reg <= cin; idx <= 0; clear sum, cout, ovf; go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - busy=1.
  - add_a, add_b are combinational: a_reg[4*idx+3 : 4*idx] and b_reg[4*idx+3 : 4*idx].
  - add_cin = carry_reg.
  - The adder is purely combinational. Each rising edge: sum[4*idx+3 : 4*idx] <= add_s; carry_reg <= add_cout; idx <= idx+1.
  - When idx = NIBBLES-1:
    - cout <= add_cout.
    - ovf <= (a_reg[W-1] == b_reg[W-1]) && (add_s[3] != a_reg[W-1]).
    - Go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then unconditionally go to IDLE.
- Latency: start accepted at edge k; done is high during the cycle after edge k+NIBBLES. That is NIBBLES+1 cycles from start to done; 5 cycles for the default.
- Throughput: one result per NIBBLES+2 cycles. A start asserted during DONE is ignored; it must be held or re-asserted in IDLE.
- start during RUN or DONE: ignored; operand inputs may change freely with no effect.
- Holding start high continuously in IDLE launches a new operation on every return to IDLE.
- In IDLE and DONE, add_a, add_b and add_cin are driven to 0.
- sum, cout and ovf stay stable from DONE until the next accepted start. Partial sum nibbles may be visible during RUN but are not valid until done.
- idx width is ceil(log2(NIBBLES)) bits and never wraps in normal operation.
- The carry chain is strictly unsigned modulo 2^W; cin is the LSB carry.

Test Plan:
- Basic add: op_a=16'h1234, op_b=16'h4321, cin=0, 1-cycle start pulse.
  - Requires: busy high for 4 cycles; done pulse 5 cycles after start; sum=16'h5555, cout=0, ovf=0.
- Carry ripple across all nibbles: op_a=16'hFFFF, op_b=16'h0001, cin=0.
  - Requires: sum=16'h0000, cout=1, ovf=0.
  - add_cin sequence 0,1,1,1 observed in RUN.
- Signed overflow plus carry-in: op_a=16'h7FFF, op_b=16'h0000, cin=1.
  - Requires: sum=16'h8000, cout=0, ovf=1.
  - Additional case: op_a=16'h8000, op_b=16'h8000, cin=0 requires sum=0, cout=1, ovf=1.
- start ignored while busy: start 16'h0001+16'h0001, then re-pulse start with 16'hAAAA+16'h5555 two cycles later.
  - Requires: exactly one done; sum=16'h0002.
  - Requires: op_a/op_b changes during RUN have no effect.
- Reset mid-operation: assert rst_n=0 asynchronously (between edges) during RUN idx=2.
  - Requires: busy, done, sum, cout, ovf read 0 immediately.
  - After release: state IDLE; a new start of 16'h00F0+16'h0010 gives sum=16'h0100 after the normal 5-cycle latency.
- Back-to-back: start held high.
  - Requires: done pulses every 6 cycles.
  - Each result matches the operands present at its accepting edge.
  - Scoreboard compares against (op_a+op_b+cin) for 200 random vectors.
